// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared constants and state type for the ping-pong buffer reader
package pingpong_pkg;

   localparam int FRAME_LEN_DEFAULT = 512;
   localparam int DATA_W_DEFAULT    = 8;
   localparam int FIFO_DEPTH        = 2;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } rd_state_t;

endpackage

// File: rtl/fifo2.sv
// rtl/fifo2.sv - two-entry output FIFO with synchronous flush
module fifo2
   import pingpong_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [FIFO_DEPTH];
   logic [W-1:0] mem_d [FIFO_DEPTH];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;

   // Flush wins over a same-cycle push so a stale in-flight byte cannot survive an abort.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/pingpong_reader.sv
// rtl/pingpong_reader.sv - streams one filled ping-pong buffer per swap edge
module pingpong_reader
   import pingpong_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
   parameter int DATA_W    = DATA_W_DEFAULT
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         swap,
   output logic [$clog2(FRAME_LEN)-1:0] r_addr,
   input  logic [DATA_W-1:0]            r_q,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         overrun
);

   localparam int                ADDR_W    = $clog2(FRAME_LEN);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;
   logic              swap_d_q, swap_d_d;
   logic              overrun_q, overrun_d;
   logic              frame_done_q, frame_done_d;

   logic              swap_edge, pop, issue, last_xfer, fifo_flush;
   logic [2:0]        occupancy;
   logic [1:0]        fifo_count;
   logic [DATA_W:0]   fifo_head;

   fifo2 #(.W(DATA_W + 1)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (fifo_flush),
      .push      (inflight_q),
      .push_data ({inflight_last_q, r_q}),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign out_valid  = (fifo_count != 2'd0);
   assign out_data   = fifo_head[DATA_W-1:0];
   assign out_last   = out_valid & fifo_head[DATA_W];
   assign pop        = out_valid & out_ready;
   assign last_xfer  = pop & fifo_head[DATA_W];
   assign swap_edge  = swap & ~swap_d_q;
   // Count the byte already in flight so the FIFO can never be asked to hold a third.
   assign occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
   assign issue      = (state_q == STREAM) && (occupancy < 3'd2);

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      inflight_d      = issue;
      inflight_last_d = issue && (addr_q == LAST_ADDR);
      swap_d_d        = swap;
      overrun_d       = overrun_q;
      frame_done_d    = last_xfer;
      fifo_flush      = 1'b0;
      case (state_q)
         IDLE: begin
            if (swap_edge) begin
               state_d = STREAM;
               addr_d  = '0;
            end
         end
         STREAM: begin
            if (issue) begin
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (last_xfer) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // An edge landing on the final transfer is a clean back-to-back start, not an overrun.
      if (swap_edge && (state_q != IDLE)) begin
         state_d = STREAM;
         addr_d  = '0;
         if (!last_xfer) begin
            overrun_d       = 1'b1;
            fifo_flush      = 1'b1;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         swap_d_q        <= 1'b1;
         overrun_q       <= 1'b0;
         frame_done_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         swap_d_q        <= swap_d_d;
         overrun_q       <= overrun_d;
         frame_done_q    <= frame_done_d;
      end
   end

   assign r_addr     = addr_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_pingpong_reader.sv
// tb/tb_pingpong_reader.sv - directed self-checking bench for pingpong_reader
module tb_pingpong_reader;

   logic       clk = 1'b0;
   logic       reset, swap, out_ready;
   logic [8:0] r_addr;
   logic [7:0] r_q, out_data;
   logic       out_valid, out_last, busy, frame_done, overrun;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q_data [$];
   logic       q_last [$];
   int         first_cyc, stall_bad, gaps, addr_snap, max_addr;

   pingpong_reader dut (
      .clk        (clk),
      .reset      (reset),
      .swap       (swap),
      .r_addr     (r_addr),
      .r_q        (r_q),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Buffer read side: mem[i] = i[7:0], one cycle read latency.
   always @(posedge clk) r_q <= r_addr[7:0];

   // Records transfers; mode 0 ready=1, mode 1 ready 1,0,0,1..., mode 2 ready=0 for 21 cycles.
   task automatic collect(input int mode, input int nmax, input int budget);
      logic       stalled;
      logic [7:0] hd;
      logic       hl;
      q_data.delete();
      q_last.delete();
      first_cyc = -1; stall_bad = 0; gaps = 0; addr_snap = -1; max_addr = 0;
      stalled = 1'b0; hd = '0; hl = 1'b0;
      for (int cyc = 1; cyc <= budget && q_data.size() < nmax; cyc++) begin
         @(negedge clk);
         if (cyc == 1) swap = 1'b0;
         if (stalled && (out_valid !== 1'b1 || out_data !== hd || out_last !== hl)) stall_bad++;
         case (mode)
            1:       out_ready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
            2:       out_ready = (cyc > 21);
            default: out_ready = 1'b1;
         endcase
         if (mode == 2 && cyc <= 21) begin
            if (int'(r_addr) > max_addr) max_addr = int'(r_addr);
            if (cyc == 21) addr_snap = int'(r_addr);
         end
         if (out_valid && out_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            q_data.push_back(out_data);
            q_last.push_back(out_last);
         end else if (first_cyc >= 0) begin
            gaps++;
         end
         stalled = out_valid && !out_ready;
         hd = out_data;
         hl = out_last;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; swap = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      checks++; if (out_last !== 1'b0)   begin errors++; $display("FAIL reset out_last: got %b expected 0", out_last); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b expected 0", frame_done); end
      checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset overrun: got %b expected 0", overrun); end
      checks++; if (r_addr !== 9'd0)     begin errors++; $display("FAIL reset r_addr: got %0d expected 0", r_addr); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b expected 0", busy); end
   endtask

   task automatic test_full_frame();
      swap = 1'b1; out_ready = 1'b1;
      collect(0, 512, 700);
      checks++; if (first_cyc != 3)        begin errors++; $display("FAIL full latency: got %0d expected 3", first_cyc); end
      checks++; if (q_data.size() != 512)  begin errors++; $display("FAIL full count: got %0d expected 512", q_data.size()); end
      checks++; if (gaps != 0)             begin errors++; $display("FAIL full gaps: got %0d expected 0", gaps); end
      checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL full busy at last: got %b expected 1", busy); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== i[7:0] || q_last[i] !== (i == 511)) begin
            errors++;
            $display("FAIL full byte %0d: got %0h/%b expected %0h/%b", i, q_data[i], q_last[i], i[7:0], (i == 511));
         end
      end
      @(negedge clk);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL full frame_done: got %b expected 1", frame_done); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL full busy after: got %b expected 0", busy); end
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL full valid after: got %b expected 0", out_valid); end
      @(negedge clk);
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL full frame_done pulse: got %b expected 0", frame_done); end
   endtask

   task automatic test_back_to_back();
      swap = 1'b1;
      collect(0, 512, 700);
      checks++; if (q_data.size() != 512) begin errors++; $display("FAIL b2b first count: got %0d expected 512", q_data.size()); end
      swap = 1'b1;
      @(negedge clk);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b frame_done: got %b expected 1", frame_done); end
      checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL b2b overrun: got %b expected 0", overrun); end
      checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL b2b busy: got %b expected 1", busy); end
      collect(0, 512, 700);
      checks++; if (first_cyc != 2)       begin errors++; $display("FAIL b2b latency: got %0d expected 2", first_cyc); end
      checks++; if (q_data.size() != 512) begin errors++; $display("FAIL b2b count: got %0d expected 512", q_data.size()); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== i[7:0] || q_last[i] !== (i == 511)) begin
            errors++;
            $display("FAIL b2b byte %0d: got %0h/%b expected %0h/%b", i, q_data[i], q_last[i], i[7:0], (i == 511));
         end
      end
      @(negedge clk);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b second frame_done: got %b expected 1", frame_done); end
   endtask

   task automatic test_ready_toggle();
      swap = 1'b1;
      collect(1, 512, 2500);
      checks++; if (q_data.size() != 512) begin errors++; $display("FAIL toggle count: got %0d expected 512", q_data.size()); end
      checks++; if (stall_bad != 0)       begin errors++; $display("FAIL toggle stall stability: got %0d changes expected 0", stall_bad); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== i[7:0] || q_last[i] !== (i == 511)) begin
            errors++;
            $display("FAIL toggle byte %0d: got %0h/%b expected %0h/%b", i, q_data[i], q_last[i], i[7:0], (i == 511));
         end
      end
      @(negedge clk);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL toggle frame_done: got %b expected 1", frame_done); end
   endtask

   task automatic test_stall();
      swap = 1'b1;
      collect(2, 512, 900);
      checks++; if (addr_snap != 2)       begin errors++; $display("FAIL stall r_addr: got %0d expected 2", addr_snap); end
      checks++; if (max_addr > 2)         begin errors++; $display("FAIL stall max r_addr: got %0d expected <=2", max_addr); end
      checks++; if (first_cyc != 22)      begin errors++; $display("FAIL stall resume: got %0d expected 22", first_cyc); end
      checks++; if (q_data.size() != 512) begin errors++; $display("FAIL stall count: got %0d expected 512", q_data.size()); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== i[7:0] || q_last[i] !== (i == 511)) begin
            errors++;
            $display("FAIL stall byte %0d: got %0h/%b expected %0h/%b", i, q_data[i], q_last[i], i[7:0], (i == 511));
         end
      end
      @(negedge clk);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stall frame_done: got %b expected 1", frame_done); end
   endtask

   task automatic test_overrun();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun before: got %b expected 0", overrun); end
      swap = 1'b1;
      collect(0, 100, 200);
      checks++; if (q_data.size() != 100) begin errors++; $display("FAIL overrun pre count: got %0d expected 100", q_data.size()); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== i[7:0] || q_last[i] !== 1'b0) begin
            errors++;
            $display("FAIL overrun pre byte %0d: got %0h/%b expected %0h/0", i, q_data[i], q_last[i], i[7:0]);
         end
      end
      swap = 1'b1;
      @(negedge clk);
      checks++; if (overrun !== 1'b1)    begin errors++; $display("FAIL overrun set: got %b expected 1", overrun); end
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL overrun flush valid: got %b expected 0", out_valid); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL overrun frame_done: got %b expected 0", frame_done); end
      collect(0, 512, 700);
      checks++; if (first_cyc != 2)       begin errors++; $display("FAIL overrun restart latency: got %0d expected 2", first_cyc); end
      checks++; if (q_data.size() != 512) begin errors++; $display("FAIL overrun count: got %0d expected 512", q_data.size()); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== i[7:0] || q_last[i] !== (i == 511)) begin
            errors++;
            $display("FAIL overrun byte %0d: got %0h/%b expected %0h/%b", i, q_data[i], q_last[i], i[7:0], (i == 511));
         end
      end
      @(negedge clk);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL overrun frame_done end: got %b expected 1", frame_done); end
      checks++; if (overrun !== 1'b1)    begin errors++; $display("FAIL overrun sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_swap_held_reset();
      int bad;
      swap = 1'b1; reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0)         begin errors++; $display("FAIL held swap started frame: got %0d busy cycles expected 0", bad); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL held reset overrun: got %b expected 0", overrun); end
      swap = 1'b0;
      @(negedge clk);
      swap = 1'b1;
      collect(0, 300, 400);
      checks++; if (first_cyc != 3)       begin errors++; $display("FAIL held latency: got %0d expected 3", first_cyc); end
      checks++; if (q_data.size() != 300) begin errors++; $display("FAIL held count: got %0d expected 300", q_data.size()); end
      for (int i = 0; i < q_data.size(); i++) begin
         checks++;
         if (q_data[i] !== i[7:0] || q_last[i] !== 1'b0) begin
            errors++;
            $display("FAIL held byte %0d: got %0h/%b expected %0h/0", i, q_data[i], q_last[i], i[7:0]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      reset = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL midreset out_valid: got %b expected 0", out_valid); end
      checks++; if (out_last !== 1'b0)   begin errors++; $display("FAIL midreset out_last: got %b expected 0", out_last); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midreset busy: got %b expected 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset frame_done: got %b expected 0", frame_done); end
      checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL midreset overrun: got %b expected 0", overrun); end
      checks++; if (r_addr !== 9'd0)     begin errors++; $display("FAIL midreset r_addr: got %0d expected 0", r_addr); end
      reset = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (frame_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midreset aftermath: got %0d active cycles expected 0", bad); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; swap = 1'b0; out_ready = 1'b0;
      test_reset();
      test_full_frame();
      test_back_to_back();
      test_ready_toggle();
      test_stall();
      test_overrun();
      test_swap_held_reset();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
